// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, state
// encoding, strobe bundle and default memory timeout.
package cpu_pkg;

    // Instruction opcodes as held in IR[1:0]
    localparam logic [1:0] OP_R  = 2'b00;
    localparam logic [1:0] OP_LW = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;
    localparam logic [1:0] OP_BR = 2'b11;

    // Default number of cycles to wait for a memory ack
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // Wait counter width; wide enough for TIMEOUT up to 255
    localparam int unsigned WAIT_W = 8;

    // Sequencer states; encodings are visible on the state output
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StError  = 3'd7
    } stateT;

    // Datapath strobes that depend only on state, latched opcode and zero
    typedef struct packed {
        logic pcWrite;
        logic pcSrc;
        logic regDst;
        logic regWrite;
        logic aluSrc;
        logic aluOp;
        logic memRead;
        logic memWrite;
        logic memtoReg;
        logic dmemReq;
    } ctrlStrobesT;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the sequencer and the datapath/memories.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             start;
    logic             halt;
    logic [1:0]       opcode;
    logic             zero;
    logic             imem_req;
    logic             imem_ack;
    logic             dmem_req;
    logic             dmem_ack;
    logic             PCWrite;
    logic             PCSrc;
    logic             IRWrite;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrc;
    logic             ALUOp;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             busy;
    logic             err;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    // Sequencer side
    modport master (
        input  start, halt, opcode, zero, imem_ack, dmem_ack,
        output imem_req, dmem_req, PCWrite, PCSrc, IRWrite, RegDst, RegWrite,
               ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, busy, err, state, retired
    );

    // Datapath / memory side
    modport slave (
        output start, halt, opcode, zero, imem_ack, dmem_ack,
        input  imem_req, dmem_req, PCWrite, PCSrc, IRWrite, RegDst, RegWrite,
               ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, busy, err, state, retired
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: (state, latched opcode, zero) -> datapath strobes.
// The fetch-side strobes live in the top because they are qualified by the ack.
module ctrl_decode
    import cpu_pkg::*;
(
    input  stateT       state,
    input  logic [1:0]  opQ,
    input  logic        zero,
    output ctrlStrobesT strobes
);

    // Decode strobes per state; everything defaults low
    always_comb begin
        strobes = '0;
        case (state)
            StExec: begin
                unique case (opQ)
                    OP_R: begin
                        strobes.aluSrc = 1'b0;
                        strobes.aluOp  = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        strobes.aluSrc = 1'b1;
                        strobes.aluOp  = 1'b1;
                    end
                    OP_BR: begin
                        // Subtract-compare; take the branch target only when equal
                        strobes.aluSrc  = 1'b0;
                        strobes.aluOp   = 1'b0;
                        strobes.pcWrite = zero;
                        strobes.pcSrc   = zero;
                    end
                endcase
            end
            StMem: begin
                // Address stays computed and request held until the ack
                strobes.dmemReq  = 1'b1;
                strobes.aluSrc   = 1'b1;
                strobes.aluOp    = 1'b1;
                strobes.memRead  = (opQ == OP_LW);
                strobes.memWrite = (opQ == OP_SW);
            end
            StWb: begin
                strobes.regWrite = 1'b1;
                strobes.regDst   = (opQ == OP_R);
                strobes.memtoReg = (opQ == OP_LW);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, timeout detection, halt at instruction boundary and a
// retired-instruction counter.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    localparam logic [WAIT_W-1:0] TimeoutLim = WAIT_W'(TIMEOUT);

    stateT             stateQ, stateD;
    logic [1:0]        opQ, opD;
    logic [WAIT_W-1:0] waitQ, waitD;
    logic [WAIT_W-1:0] waitInc;
    logic              waitHit;
    logic [CNT_W-1:0]  retiredQ, retiredD;
    logic              haltPendQ, haltPendD;
    logic              fetchActive;
    logic              fetchGrant;
    ctrlStrobesT       dec;

    // A pending halt turns the next FETCH into a bubble that returns to IDLE
    assign fetchActive = (stateQ == StFetch) && !haltPendQ;
    assign fetchGrant  = fetchActive && bus.imem_ack;

    // Saturating wait count; reaching the limit this cycle is a timeout unless acked
    assign waitInc = (waitQ >= TimeoutLim) ? TimeoutLim : waitQ + WAIT_W'(1);
    assign waitHit = (waitInc == TimeoutLim);

    // State, opcode latch, wait counter and retire counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StIdle;
            opQ       <= OP_R;
            waitQ     <= '0;
            retiredQ  <= '0;
            haltPendQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            opQ       <= opD;
            waitQ     <= waitD;
            retiredQ  <= retiredD;
            haltPendQ <= haltPendD;
        end
    end

    // Next-state, wait counter and retire logic
    always_comb begin
        stateD   = stateQ;
        opD      = opQ;
        waitD    = '0;
        retiredD = retiredQ;
        case (stateQ)
            StIdle: begin
                if (bus.start) stateD = StFetch;
            end
            StFetch: begin
                if (haltPendQ)         stateD = StIdle;
                else if (bus.imem_ack) stateD = StDecode;
                else if (waitHit)      stateD = StError;
                else                   waitD  = waitInc;
            end
            StDecode: begin
                opD    = bus.opcode;
                stateD = StExec;
            end
            StExec: begin
                unique case (opQ)
                    OP_R:         stateD = StWb;
                    OP_LW, OP_SW: stateD = StMem;
                    OP_BR: begin
                        retiredD = retiredQ + CNT_W'(1);
                        stateD   = StFetch;
                    end
                endcase
            end
            StMem: begin
                if (bus.dmem_ack) begin
                    if (opQ == OP_LW) begin
                        stateD = StWb;
                    end else begin
                        retiredD = retiredQ + CNT_W'(1);
                        stateD   = StFetch;
                    end
                end else if (waitHit) begin
                    stateD = StError;
                end else begin
                    waitD = waitInc;
                end
            end
            StWb: begin
                retiredD = retiredQ + CNT_W'(1);
                stateD   = StFetch;
            end
            StError: stateD = StError;
            default: stateD = StIdle;
        endcase
    end

    // Remember a halt request raised while running until the next boundary
    always_comb begin
        haltPendD = haltPendQ;
        if (stateQ inside {StIdle, StError}) haltPendD = 1'b0;
        else if (bus.halt)                   haltPendD = 1'b1;
        if (stateD == StIdle)                haltPendD = 1'b0;
    end

    ctrl_decode uDecode (
        .state   (stateQ),
        .opQ     (opQ),
        .zero    (bus.zero),
        .strobes (dec)
    );

    assign bus.imem_req = fetchActive;
    assign bus.IRWrite  = fetchGrant;
    assign bus.PCWrite  = fetchGrant | dec.pcWrite;
    assign bus.PCSrc    = dec.pcSrc;
    assign bus.dmem_req = dec.dmemReq;
    assign bus.RegDst   = dec.regDst;
    assign bus.RegWrite = dec.regWrite;
    assign bus.ALUSrc   = dec.aluSrc;
    assign bus.ALUOp    = dec.aluOp;
    assign bus.MemRead  = dec.memRead;
    assign bus.MemWrite = dec.memWrite;
    assign bus.MemtoReg = dec.memtoReg;
    assign bus.busy     = !(stateQ inside {StIdle, StError});
    assign bus.err      = (stateQ == StError);
    assign bus.state    = stateQ;
    assign bus.retired  = retiredQ;

endmodule
